clk_div_monitor: RTL and testbench

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_monitor.sv | 156 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures high/low phase lengths of i_div_clk in i_ref_clk cycles,
// flags period mismatches against the expected ratio, detects stalls and tracks lock.
module clk_div_monitor #(
  parameter int LOCK_CNT = 4,
  parameter int TMO_MAX  = 31
) (
  input  logic       i_ref_clk,
  input  logic       i_rst,
  input  logic       i_mon_en,
  input  logic       i_div_clk,
  input  logic [4:0] i_exp_ratio,
  output logic [4:0] o_high_cnt,
  output logic [4:0] o_low_cnt,
  output logic [5:0] o_ratio,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_timeout,
  output logic       o_lock
);

  // state | meaning
  // IDLE  | disabled or bypassed, nothing measured
  // SYNC  | waiting for a rising edge to start a clean period
  // HIGH  | counting the high phase
  // LOW   | counting the low phase; next rise completes the period
  typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic        d_q;
  logic [4:0]  exp_q;
  logic [4:0]  hi_q, hi_d, lo_q, lo_d;
  logic [2:0]  mcnt_q, mcnt_d, mcnt_inc;
  logic        lock_d, pub, err_d, tmo_d;
  logic        rise, fall, bypass, exp_chg, match;
  logic [4:0]  half;
  logic [5:0]  sum;

  assign rise    = i_div_clk & ~d_q;
  assign fall    = ~i_div_clk & d_q;
  assign bypass  = (i_exp_ratio <= 5'd1);
  assign exp_chg = (i_exp_ratio != exp_q);
  assign half    = exp_q >> 1;
  assign sum     = {1'b0, hi_q} + {1'b0, lo_q};

  // The sum check rules out the half/half+1 split for even ratios.
  assign match = (sum == {1'b0, exp_q}) &&
                 (((hi_q == half) && (lo_q == half)) ||
                  ((hi_q == half) && (lo_q == half + 5'd1)) ||
                  ((hi_q == half + 5'd1) && (lo_q == half)));

  assign mcnt_inc = (mcnt_q >= 3'(LOCK_CNT)) ? mcnt_q : mcnt_q + 3'd1;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcnt_d  = mcnt_q;
    lock_d  = o_lock;
    pub     = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    if (!i_mon_en || bypass || exp_chg) begin
      state_d = (!i_mon_en || bypass) ? IDLE : SYNC;
      hi_d    = '0;
      lo_d    = '0;
      mcnt_d  = '0;
      lock_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (rise) begin
            state_d = HIGH;
            hi_d    = 5'd1;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            lo_d    = 5'd1;
          end else if (hi_q == 5'(TMO_MAX)) begin
            state_d = SYNC;
            tmo_d   = 1'b1;
            hi_d    = '0;
            lo_d    = '0;
            mcnt_d  = '0;
            lock_d  = 1'b0;
          end else if (i_div_clk) begin
            hi_d = hi_q + 5'd1;
          end
        end
        LOW: begin
          if (rise) begin
            state_d = HIGH;
            pub     = 1'b1;
            hi_d    = 5'd1;
            lo_d    = '0;
            if (match) begin
              mcnt_d = mcnt_inc;
              lock_d = (mcnt_inc >= 3'(LOCK_CNT));
            end else begin
              err_d  = 1'b1;
              mcnt_d = '0;
              lock_d = 1'b0;
            end
          end else if (lo_q == 5'(TMO_MAX)) begin
            state_d = SYNC;
            tmo_d   = 1'b1;
            hi_d    = '0;
            lo_d    = '0;
            mcnt_d  = '0;
            lock_d  = 1'b0;
          end else if (!i_div_clk) begin
            lo_d = lo_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      d_q        <= 1'b0;
      exp_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mcnt_q     <= '0;
      o_high_cnt <= '0;
      o_low_cnt  <= '0;
      o_ratio    <= '0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_timeout  <= 1'b0;
      o_lock     <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= i_div_clk;
      exp_q     <= i_exp_ratio;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcnt_q    <= mcnt_d;
      o_valid   <= pub;
      o_err     <= err_d;
      o_timeout <= tmo_d;
      o_lock    <= lock_d;
      if (pub) begin
        o_high_cnt <= hi_q;
        o_low_cnt  <= lo_q;
        o_ratio    <= sum;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: directed periods push expected publications,
// an independent monitor pops and compares whenever o_valid or o_timeout fires.
module tb_clk_div_monitor;

  logic       clk = 1'b0;
  logic       rst, en, div;
  logic [4:0] exp_r;
  logic [4:0] high_cnt, low_cnt;
  logic [5:0] ratio;
  logic       valid, err, timeout, lock;

  clk_div_monitor #(.LOCK_CNT(4), .TMO_MAX(31)) dut (
    .i_ref_clk  (clk),
    .i_rst      (rst),
    .i_mon_en   (en),
    .i_div_clk  (div),
    .i_exp_ratio(exp_r),
    .o_high_cnt (high_cnt),
    .o_low_cnt  (low_cnt),
    .o_ratio    (ratio),
    .o_valid    (valid),
    .o_err      (err),
    .o_timeout  (timeout),
    .o_lock     (lock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         tmo;
    logic [4:0] hi;
    logic [4:0] lo;
    logic [5:0] ratio;
    bit         err;
    bit         lock;
    int         at;
  } item_t;

  item_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 div = v;
    end
  endtask

  // One full period; it is published when the next rise is sampled.
  task automatic per(input int h, input int l, input bit e, input bit lk);
    item_t it;
    drive(1'b1, h);
    drive(1'b0, l);
    it.tmo   = 1'b0;
    it.hi    = 5'(h);
    it.lo    = 5'(l);
    it.ratio = 6'(h + l);
    it.err   = e;
    it.lock  = lk;
    it.at    = 0;
    sbq.push_back(it);
  endtask

  // Start one more period so the previous one publishes, then switch ratio.
  task automatic tail_switch(input logic [4:0] new_exp);
    drive(1'b1, 1);
    @(posedge clk);
    #1 begin exp_r = new_exp; div = 1'b0; end
    drive(1'b0, 3);
  endtask

  initial begin
    item_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 || timeout === 1'b1) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: valid=%0b timeout=%0b hi=%0d lo=%0d ratio=%0d",
                   valid, timeout, high_cnt, low_cnt, ratio);
        end else begin
          e = sbq.pop_front();
          if (e.tmo)
            ok = (timeout === 1'b1) && (valid === 1'b0) && (lock === e.lock) && (cyc == e.at);
          else
            ok = (valid === 1'b1) && (timeout === 1'b0) && (high_cnt === e.hi) &&
                 (low_cnt === e.lo) && (ratio === e.ratio) && (err === e.err) &&
                 (lock === e.lock);
          if (!ok)
            $display("FAIL scoreboard: got v=%0b t=%0b hi=%0d lo=%0d r=%0d err=%0b lock=%0b cyc=%0d expected t=%0b hi=%0d lo=%0d r=%0d err=%0b lock=%0b at=%0d",
                     valid, timeout, high_cnt, low_cnt, ratio, err, lock, cyc,
                     e.tmo, e.hi, e.lo, e.ratio, e.err, e.lock, e.at);
          if (!ok) bad++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t t;
    rst = 1'b1; en = 1'b0; div = 1'b0; exp_r = 5'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_high_cnt", high_cnt, 0);
    chk("rst_low_cnt", low_cnt, 0);
    chk("rst_ratio", ratio, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_lock", lock, 0);
    @(posedge clk);
    #1 begin rst = 1'b0; en = 1'b1; end
    drive(1'b0, 3);

    // even ratio 4
    per(2, 2, 0, 0); per(2, 2, 0, 0); per(2, 2, 0, 0);
    per(2, 2, 0, 1); per(2, 2, 0, 1);
    tail_switch(5'd5);

    // odd ratio 5, alternating phase split
    per(2, 3, 0, 0); per(3, 2, 0, 0); per(2, 3, 0, 0);
    per(3, 2, 0, 1); per(2, 3, 0, 1);
    tail_switch(5'd6);

    // ratio 6: lock, mismatch, relock, then a one-cycle glitch
    per(3, 3, 0, 0); per(3, 3, 0, 0); per(3, 3, 0, 0); per(3, 3, 0, 1);
    per(3, 4, 1, 0);
    per(3, 3, 0, 0); per(3, 3, 0, 0); per(3, 3, 0, 0); per(3, 3, 0, 1);
    per(1, 5, 1, 0);
    per(3, 3, 0, 0);

    // stall high for 40 cycles; timeout when the high counter has reached 31
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 div = 1'b1;
      if (i == 0) begin
        t.tmo = 1'b1; t.hi = '0; t.lo = '0; t.ratio = '0;
        t.err = 1'b0; t.lock = 1'b0; t.at = cyc + 32;
        sbq.push_back(t);
      end
    end
    drive(1'b0, 2);
    per(3, 3, 0, 0); per(3, 3, 0, 0);
    tail_switch(5'd4);

    // ratio change 4 -> 8 in the middle of a period
    per(2, 2, 0, 0); per(2, 2, 0, 0); per(2, 2, 0, 0); per(2, 2, 0, 1);
    drive(1'b1, 2);
    drive(1'b0, 1);
    @(posedge clk);
    #1 begin exp_r = 5'd8; div = 1'b0; end
    @(negedge clk);
    chk("lock_before_change", lock, 1);
    @(negedge clk);
    chk("lock_after_change", lock, 0);
    drive(1'b0, 2);
    per(4, 4, 0, 0); per(4, 4, 0, 0);
    tail_switch(5'd1);

    // bypass: no publications expected at all
    repeat (4) begin
      drive(1'b1, 2);
      drive(1'b0, 2);
    end
    drive(1'b1, 2);
    @(negedge clk);
    chk("bypass_lock", lock, 0);
    @(posedge clk);
    #1 begin exp_r = 5'd4; div = 1'b0; end
    drive(1'b0, 3);

    // reset mid-LOW after locking
    per(2, 2, 0, 0); per(2, 2, 0, 0); per(2, 2, 0, 0); per(2, 2, 0, 1);
    drive(1'b1, 2);
    drive(1'b0, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_high_cnt", high_cnt, 0);
    chk("midrst_low_cnt", low_cnt, 0);
    chk("midrst_ratio", ratio, 0);
    chk("midrst_lock", lock, 0);
    chk("midrst_valid", valid, 0);
    drive(1'b0, 3);
    per(2, 2, 0, 0);
    drive(1'b1, 1);
    drive(1'b0, 2);

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    chk("queue_drained", sbq.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
